si53xx_spi_responder: RTL and testbench

- Synthesizable SPI slave implementing the Si53xx register-access protocol: the device end of the link driven by si53xx_spi_interface.
- Holds a 256 x 8 register file and decodes the Si53xx instruction set (set address, write, read, and auto-increment variants).
- Serves as an on-FPGA loopback target for PLL configuration sequencers and as a bench model.
- SPI pins are oversampled in the system clock domain.

---
 rtl/si53xx_pkg.sv | 36 +++
 rtl/si53xx_spi_pin_sync.sv | 33 +++
 rtl/si53xx_spi_responder.sv | 200 ++++++++++++++++++++
 tb/tb_si53xx_spi_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/si53xx_pkg.sv
// Shared constants, FSM state type and opcode helpers for the Si53xx SPI responder.
package si53xx_pkg;

    localparam int FRAME_BITS = 16;
    localparam int HALF_BITS  = FRAME_BITS / 2;

    localparam logic [7:0] OP_SETADDR   = 8'h00;
    localparam logic [7:0] OP_WRITE     = 8'h40;
    localparam logic [7:0] OP_WRITE_INC = 8'hC0;
    localparam logic [7:0] OP_READ      = 8'h80;
    localparam logic [7:0] OP_READ_INC  = 8'hA0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_e;

    function automatic logic op_is_read(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_READ_INC);
    endfunction

    function automatic logic op_is_write(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_WRITE_INC);
    endfunction

    function automatic logic op_is_inc(input logic [7:0] op);
        return (op == OP_WRITE_INC) || (op == OP_READ_INC);
    endfunction

    function automatic logic op_is_known(input logic [7:0] op);
        return (op == OP_SETADDR) || op_is_write(op) || op_is_read(op);
    endfunction

endpackage

// File: rtl/si53xx_spi_pin_sync.sv
// Multi-bit pin synchronizer with rise/fall detection from the last two synchronized samples.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // Chain resets low so a chip select already low at release never looks like a falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/si53xx_spi_responder.sv
// Si53xx register-access SPI slave: 256x8 register file, instruction decoder and
// mode-0 shift logic, all running in the oversampling system clock domain.
module si53xx_spi_responder
    import si53xx_pkg::*;
#(
    parameter logic [7:0] DEV_ID      = 8'h16,
    parameter logic [7:0] ID_ADDR     = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       nCS,
    input  logic       sclk,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic [7:0] cur_addr,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err
);

    logic [2:0] pin_lvl, pin_rise, pin_fall;

    spi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .WIDTH      (3)
    ) u_pin_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .pin_i  ({sdi, sclk, nCS}),
        .level_o(pin_lvl),
        .rise_o (pin_rise),
        .fall_o (pin_fall)
    );

    logic ncs_lvl, ncs_rise, ncs_fall, sclk_rise, sclk_fall, sdi_s;
    logic sync_unused;

    assign ncs_lvl     = pin_lvl[0];
    assign ncs_rise    = pin_rise[0];
    assign ncs_fall    = pin_fall[0];
    assign sclk_rise   = pin_rise[1];
    assign sclk_fall   = pin_fall[1];
    assign sdi_s       = pin_lvl[2];
    assign sync_unused = ^{pin_lvl[1], pin_rise[2], pin_fall[2]};

    state_e     state_q, state_d;
    logic [3:0] edge_cnt_q, edge_cnt_d;
    logic [7:0] shift_in_q, shift_in_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] shift_out_q, shift_out_d;
    logic       extra_q, extra_d;
    logic       sdo_q, sdo_d;
    logic       sdo_oe_q, sdo_oe_d;
    logic [7:0] cur_addr_q, cur_addr_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       frame_err_q, frame_err_d;

    logic [7:0] regs_q [256];
    logic [7:0] rx_byte;
    logic [7:0] rd_data;
    logic       reg_we;

    assign rx_byte = {shift_in_q[6:0], sdi_s};
    assign rd_data = (cur_addr_q == ID_ADDR) ? DEV_ID : regs_q[cur_addr_q];

    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d     = state_q;
        edge_cnt_d  = edge_cnt_q;
        shift_in_d  = shift_in_q;
        instr_d     = instr_q;
        shift_out_d = shift_out_q;
        extra_d     = extra_q;
        sdo_d       = sdo_q;
        cur_addr_d  = cur_addr_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        reg_we      = 1'b0;

        if (ncs_rise) begin
            state_d     = ST_IDLE;
            sdo_d       = 1'b0;
            shift_out_d = '0;
            case (state_q)
                ST_CMD, ST_DATA: frame_err_d = 1'b1;
                ST_DONE:         frame_err_d = extra_q || !op_is_known(instr_q);
                default:         frame_err_d = 1'b0;
            endcase
        end else begin
            if (sclk_fall && state_q != ST_IDLE) begin
                sdo_d       = shift_out_q[7];
                shift_out_d = {shift_out_q[6:0], 1'b0};
            end

            case (state_q)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        state_d     = ST_CMD;
                        edge_cnt_d  = '0;
                        extra_d     = 1'b0;
                        shift_out_d = '0;
                        sdo_d       = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shift_in_d = rx_byte;
                        edge_cnt_d = edge_cnt_q + 4'd1;
                        if (edge_cnt_q == 4'(HALF_BITS - 1)) begin
                            state_d     = ST_DATA;
                            instr_d     = rx_byte;
                            shift_out_d = op_is_read(rx_byte) ? rd_data : 8'h00;
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_rise) begin
                        shift_in_d = rx_byte;
                        edge_cnt_d = edge_cnt_q + 4'd1;
                        if (edge_cnt_q == 4'(FRAME_BITS - 1)) begin
                            state_d = ST_DONE;
                            if (instr_q == OP_SETADDR) cur_addr_d = rx_byte;
                            if (op_is_write(instr_q)) begin
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = cur_addr_q;
                                wr_data_d   = rx_byte;
                                reg_we      = (cur_addr_q != ID_ADDR);
                            end
                            if (op_is_inc(instr_q)) cur_addr_d = cur_addr_q + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (sclk_rise) extra_d = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        sdo_oe_d = !ncs_lvl && (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            edge_cnt_q  <= '0;
            shift_in_q  <= '0;
            instr_q     <= '0;
            shift_out_q <= '0;
            extra_q     <= 1'b0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            cur_addr_q  <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            edge_cnt_q  <= edge_cnt_d;
            shift_in_q  <= shift_in_d;
            instr_q     <= instr_d;
            shift_out_q <= shift_out_d;
            extra_q     <= extra_d;
            sdo_q       <= sdo_d;
            sdo_oe_q    <= sdo_oe_d;
            cur_addr_q  <= cur_addr_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // NOTE: the register file must read back as zero after reset, so it is built from resettable flops rather than a RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) regs_q[i] <= '0;
        end else if (reg_we) begin
            regs_q[cur_addr_q] <= rx_byte;
        end
    end

    assign sdo       = sdo_q;
    assign sdo_oe    = sdo_oe_q;
    assign cur_addr  = cur_addr_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_si53xx_spi_responder.sv
// Scoreboard bench for si53xx_spi_responder: directed protocol cases followed by random frames.
module tb_si53xx_spi_responder;

    localparam int HALF = 8;
    localparam logic [7:0] T_DEV_ID   = 8'h16;
    localparam logic [7:0] T_SETADDR  = 8'h00;
    localparam logic [7:0] T_WRITE    = 8'h40;
    localparam logic [7:0] T_WRITE_I  = 8'hC0;
    localparam logic [7:0] T_READ     = 8'h80;
    localparam logic [7:0] T_READ_I   = 8'hA0;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       nCS     = 1'b1;
    logic       sclk    = 1'b0;
    logic       sdi     = 1'b0;
    logic       sdo, sdo_oe, wr_strobe, frame_err;
    logic [7:0] cur_addr, wr_addr, wr_data;

    always #5 clk = ~clk;

    si53xx_spi_responder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .nCS      (nCS),
        .sclk     (sclk),
        .sdi      (sdi),
        .sdo      (sdo),
        .sdo_oe   (sdo_oe),
        .cur_addr (cur_addr),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frame_err(frame_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain byte array and an address pointer.
    logic [7:0] m_mem [256];
    logic [7:0] m_addr = 8'h00;

    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int frame; logic [7:0] data; } rd_t;

    wr_t exp_wr_q[$];
    rd_t exp_rd_q[$];
    int  exp_err_q[$];
    int  frame_id     = 0;
    int  frames_ended = 0;

    function automatic logic is_known(input logic [7:0] op);
        return op == T_SETADDR || op == T_WRITE || op == T_WRITE_I || op == T_READ || op == T_READ_I;
    endfunction

    function automatic void model_frame(input logic [7:0] op, input logic [7:0] d, input int n);
        wr_t w;
        rd_t r;
        if (n < 16) begin
            exp_err_q.push_back(frame_id);
            return;
        end
        r.frame = frame_id;
        if (op == T_SETADDR) begin
            m_addr = d;
        end else if (op == T_WRITE || op == T_WRITE_I) begin
            w.addr = m_addr;
            w.data = d;
            exp_wr_q.push_back(w);
            if (m_addr != 8'h00) m_mem[m_addr] = d;
            if (op == T_WRITE_I) m_addr = m_addr + 8'd1;
        end else if (op == T_READ || op == T_READ_I) begin
            r.data = (m_addr == 8'h00) ? T_DEV_ID : m_mem[m_addr];
            if (n == 16) exp_rd_q.push_back(r);
            if (op == T_READ_I) m_addr = m_addr + 8'd1;
        end else if (n == 16) begin
            r.data = 8'h00;
            exp_rd_q.push_back(r);
        end
        if (n > 16 || !is_known(op)) exp_err_q.push_back(frame_id);
    endfunction

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_frame(input logic [7:0] op, input logic [7:0] d, input int n);
        logic [15:0] w;
        w = {op, d};
        frame_id++;
        model_frame(op, d, n);
        nCS = 1'b0;
        clk_wait(HALF);
        for (int i = 0; i < n; i++) begin
            sdi = (i < 16) ? w[15-i] : 1'b0;
            clk_wait(HALF);
            sclk = 1'b1;
            clk_wait(HALF);
            sclk = 1'b0;
            if (i == 3) check("sdo_oe_in_frame", 32'(sdo_oe), 32'd1);
        end
        clk_wait(HALF);
        nCS = 1'b1;
        clk_wait(3 * HALF);
        check("cur_addr", 32'(cur_addr), 32'(m_addr));
        check("sdo_idle", 32'(sdo), 32'd0);
        check("sdo_oe_idle", 32'(sdo_oe), 32'd0);
    endtask

    // Monitor: read bytes captured on sclk rising, compared at frame end.
    logic [15:0] rx_sr = '0;
    always @(posedge sclk) if (!nCS) rx_sr = {rx_sr[14:0], sdo};

    always @(posedge nCS) begin : mon_rd
        rd_t e;
        frames_ended++;
        if (exp_rd_q.size() > 0 && exp_rd_q[0].frame == frames_ended) begin
            e = exp_rd_q.pop_front();
            check("read_data", 32'(rx_sr[7:0]), 32'(e.data));
        end
    end

    // Monitor: write strobes and frame errors against the scoreboard queues.
    always @(negedge clk) begin : mon_evt
        wr_t e;
        int  f;
        if (wr_strobe) begin
            if (exp_wr_q.size() == 0) begin
                check("wr_strobe_unexpected", 32'(wr_strobe), 32'd0);
            end else begin
                e = exp_wr_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
        if (frame_err) begin
            if (exp_err_q.size() == 0) begin
                check("frame_err_unexpected", 32'(frame_err), 32'd0);
            end else begin
                f = exp_err_q.pop_front();
                check("frame_err_frame", 32'(frames_ended), 32'(f));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_sdo"}, 32'(sdo), 32'd0);
        check({tag, "_sdo_oe"}, 32'(sdo_oe), 32'd0);
        check({tag, "_cur_addr"}, 32'(cur_addr), 32'd0);
        check({tag, "_wr_strobe"}, 32'(wr_strobe), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin : stim
        logic [15:0] w;
        logic [7:0]  op, d;
        int          n, sel;

        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        clk_wait(5);
        check_all_zero("reset");
        reset_n = 1'b1;
        clk_wait(4 * HALF);

        // Write then read back.
        spi_frame(T_SETADDR, 8'h2A, 16);
        spi_frame(T_WRITE, 8'h5C, 16);
        spi_frame(T_READ, 8'h00, 16);

        // Auto-increment across the FF -> 00 wrap.
        spi_frame(T_SETADDR, 8'hFE, 16);
        spi_frame(T_WRITE_I, 8'h11, 16);
        spi_frame(T_WRITE_I, 8'h22, 16);
        spi_frame(T_WRITE_I, 8'h33, 16);
        spi_frame(T_SETADDR, 8'hFE, 16);
        spi_frame(T_READ_I, 8'h00, 16);
        spi_frame(T_READ_I, 8'h00, 16);
        spi_frame(T_READ_I, 8'h00, 16);

        // ID register is read-only.
        spi_frame(T_SETADDR, 8'h00, 16);
        spi_frame(T_READ, 8'h00, 16);
        spi_frame(T_WRITE, 8'hAA, 16);
        spi_frame(T_READ, 8'h00, 16);

        // Short frame aborts, unknown opcode, long frame.
        spi_frame(T_SETADDR, 8'h30, 16);
        spi_frame(T_WRITE, 8'h77, 11);
        spi_frame(T_READ, 8'h00, 16);
        spi_frame(8'h55, 8'hC3, 16);
        spi_frame(T_WRITE, 8'h4B, 18);
        spi_frame(T_READ, 8'h00, 16);

        // Reset in the middle of a READ, with nCS still low at release.
        frame_id++;
        w = {T_READ, 8'h00};
        nCS = 1'b0;
        clk_wait(HALF);
        for (int i = 0; i < 10; i++) begin
            sdi = w[15-i];
            clk_wait(HALF);
            sclk = 1'b1;
            clk_wait(HALF);
            sclk = 1'b0;
        end
        clk_wait(2);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_addr = 8'h00;
        clk_wait(4);
        reset_n = 1'b1;
        clk_wait(2 * HALF);
        nCS = 1'b1;
        clk_wait(3 * HALF);
        check("cur_addr_after_reset", 32'(cur_addr), 32'd0);
        spi_frame(T_SETADDR, 8'h2A, 16);
        spi_frame(T_READ, 8'h00, 16);
        spi_frame(T_WRITE, 8'h99, 16);
        spi_frame(T_READ, 8'h00, 16);

        // Random traffic.
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 9);
            d   = 8'($urandom);
            case (sel)
                0, 1: begin
                    op = T_SETADDR;
                    d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hFC, 8'hFF)) : 8'($urandom_range(0, 7));
                end
                2:    op = T_WRITE;
                3, 4: op = T_WRITE_I;
                5:    op = T_READ;
                6, 7: op = T_READ_I;
                default: begin
                    op = 8'($urandom);
                    while (is_known(op)) op = 8'($urandom);
                end
            endcase
            n = 16;
            if ($urandom_range(0, 9) == 0) n = $urandom_range(3, 15);
            else if ($urandom_range(0, 9) == 0) n = $urandom_range(17, 18);
            spi_frame(op, d, n);
        end

        clk_wait(50);
        check("exp_wr_left", 32'(exp_wr_q.size()), 32'd0);
        check("exp_rd_left", 32'(exp_rd_q.size()), 32'd0);
        check("exp_err_left", 32'(exp_err_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
